mux_rr_sched: RTL
=================

Name: mux_rr_sched

Overview:
Round-robin scheduler that drives the select/valid inputs of the 4:1 registered channel mux directly downstream. Four sources raise requests. The scheduler grants one source at a time for a burst of up to BURST_LEN beats. During the burst it drives sel (source index) and valid, one cycle per beat. Sources see their grant one-hot so they can present data on their mux input while granted.

Parameters:
BURST_LEN, 8, beats per completed grant; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  global enable; low freezes an active burst
req  in  4  per-source request; bit i = source i (i = mux input a,b,c,d order)
sel  out  2  index of the granted source; drives mux sel
valid  out  1  beat strobe; drives mux valid
grant  out  4  one-hot grant; all-zero when idle
burst_done  out  1  high in the cycle of the BURST_LEN-th beat of a burst
busy  out  1  high while a grant is held (state GRANT)

Behaviour:
- Reset is asynchronous, active-high on reset; clock is clk.
- Reset values:
  - Outputs: sel=0, valid=0, grant=0, burst_done=0, busy=0.
  - State: state=IDLE, beat count=0.
  - RR pointer last=3, so source 0 has first priority.
- Reset asserted mid-burst clears everything immediately, with no clock edge needed. No partial-burst bookkeeping survives.
- All outputs are registered.
- Beat rule: a beat appears in the cycle after edge E iff, at E, en=1 and req[granted source]=1 and the burst is not complete.
- Arbitration: search starts at (last+1) mod 4 and wraps. The first set req bit wins. Arbitration is pure combinational and lives in a sub-module.
- State IDLE:
  - At an edge with en=1 and |req, go to GRANT with the winner latched into sel/grant.
  - The first beat is issued in the same next cycle (valid=1, count=1).
  - Latency: req sampled at edge N gives valid high in cycle N+1.
- State GRANT: sel and grant are constant for the whole grant.
- Beat count increments per beat only.
- Completion:
  - When the beat just issued is beat BURST_LEN, burst_done=1 that same cycle.
  - At the next edge, last:=sel and arbitration reruns with the current req and en.
  - If a winner exists, its first beat follows with no bubble (back-to-back). The same source is allowed when it is the only requester.
  - Otherwise go to IDLE: valid=0, grant=0, busy=0.
- Early drop:
  - req[sel]=0 sampled at an edge in GRANT ends the burst: no beat, no burst_done, last:=sel, go to IDLE.
  - A new grant can start at the following edge (one bubble cycle).
- en=0 in GRANT: valid=0 and count held. grant, sel and busy are held.
  - Drop takes precedence over en; a drop is honoured even with en=0.
- en=0 in IDLE: no grant.
- burst_done is never asserted without valid in the same cycle.
- Invariants:
  - grant is one-hot or zero.
  - grant[sel]=1 whenever busy.
  - valid implies busy.
  - Total beats per completed burst = exactly BURST_LEN.

Decomposition:
- Package mux_pkg:
  - NUM_CH=4 and SEL_W=2.
  - typedef ch_idx_t (logic [SEL_W-1:0]).
  - typedef sched_state_t enum {IDLE, GRANT}.
  - Function onehot4(ch_idx_t).
- Sub-module rr_pick4: inputs req[3:0] and last ch_idx_t; outputs found and win ch_idx_t. Purely combinational, reused by later arbiters.

Test Plan:
1. BURST_LEN=4, reset then req=0001 held → valid high 8 consecutive cycles, sel=0, grant=0001, burst_done on cycles 4 and 8, no bubble between bursts.
2. BURST_LEN=4, req=1111 held → 16 consecutive valid cycles, sel sequence 0,1,2,3 (4 each), burst_done every 4th cycle, then sel=0 again.
3. BURST_LEN=4, req=0100, deassert req[2] after 2 beats → exactly 2 valid cycles with sel=2, no burst_done. valid, grant and busy go to 0 on the next cycle. With req=0001 also pending, sel=0 starts after one bubble.
4. BURST_LEN=4, req=0010, en low for 3 cycles after beat 2 → valid low for 3 cycles while sel=1 and busy held, then 2 more beats, burst_done on the last. Total beats = 4.
5. Assert reset between edges mid-burst → all outputs read 0 before the next clk edge. After release with req=1001 → first grant is sel=0.
6. BURST_LEN=1, req=0011 held → valid every cycle, sel alternating 0,1,0,1, burst_done high every cycle.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// Shared types and helpers for the 4-channel round-robin mux scheduler
// and the arbiters that will be built on the same picker.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // One-hot grant vector for a channel index.
    function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// Request/grant/beat bundle between the sources, the scheduler and the
// downstream registered channel mux. The master side is the scheduler.
interface mux_rr_sched_if;
    import mux_pkg::*;

    logic                 en;
    logic [NUM_CH-1:0]    req;
    ch_idx_t              sel;
    logic                 valid;
    logic [NUM_CH-1:0]    grant;
    logic                 burst_done;
    logic                 busy;

    modport master (
        input  en,
        input  req,
        output sel,
        output valid,
        output grant,
        output burst_done,
        output busy
    );

    modport slave (
        output en,
        output req,
        input  sel,
        input  valid,
        input  grant,
        input  burst_done,
        input  busy
    );

endinterface

// File: rtl/mux_rr_sched_pick.sv
// Combinational round-robin picker: the first set request at or after
// last+1 (wrapping) wins. No state; the caller owns the pointer.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           last,
    output logic              found,
    output ch_idx_t           win
);

    ch_idx_t idx_s;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        win   = last;
        idx_s = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx_s = last + ch_idx_t'(i);
            if (req[idx_s]) begin
                found = 1'b1;
                win   = idx_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin burst scheduler driving sel/valid of the downstream 4:1
// registered channel mux. One source owns the mux for up to BURST_LEN
// beats; completion re-arbitrates without a bubble, an early request drop
// returns to IDLE for one cycle. All outputs come straight from flops.
module mux_rr_sched
    import mux_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic            clk,
    input  logic            reset,
    mux_rr_sched_if.master  bus
);

    localparam logic [7:0] BL_C = 8'(BURST_LEN);

    sched_state_t       state_r;
    logic [7:0]         cnt_r;
    ch_idx_t            last_r;
    ch_idx_t            sel_r;
    logic [NUM_CH-1:0]  grant_r;
    logic               valid_r;
    logic               done_r;
    logic               busy_r;

    ch_idx_t            pick_last_s;
    logic               found_s;
    ch_idx_t            win_s;
    logic               own_req_s;
    logic               complete_s;

    // On completion the pointer advances to the current owner before the
    // rerun, so the picker sees sel_r while granted and last_r when idle.
    always_comb begin
        pick_last_s = last_r;
        if (state_r == GRANT) begin
            pick_last_s = sel_r;
        end else begin
            pick_last_s = last_r;
        end
        own_req_s  = bus.req[sel_r];
        complete_s = (cnt_r == BL_C);
    end

    rr_pick4 u_pick (
        .req   (bus.req),
        .last  (pick_last_s),
        .found (found_s),
        .win   (win_s)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            last_r  <= ch_idx_t'(NUM_CH - 1);
            sel_r   <= '0;
            grant_r <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.en && found_s) begin
                        state_r <= GRANT;
                        sel_r   <= win_s;
                        grant_r <= onehot4(win_s);
                        cnt_r   <= 8'd1;
                        valid_r <= 1'b1;
                        done_r  <= (BL_C == 8'd1);
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= 8'd0;
                        grant_r <= '0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (complete_s) begin
                        // Burst finished: rotate and rerun arbitration.
                        last_r <= sel_r;
                        if (bus.en && found_s) begin
                            sel_r   <= win_s;
                            grant_r <= onehot4(win_s);
                            cnt_r   <= 8'd1;
                            valid_r <= 1'b1;
                            done_r  <= (BL_C == 8'd1);
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            cnt_r   <= 8'd0;
                            grant_r <= '0;
                            valid_r <= 1'b0;
                            done_r  <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else if (!own_req_s) begin
                        // Owner withdrew: abandon the burst, even with en low.
                        last_r  <= sel_r;
                        state_r <= IDLE;
                        cnt_r   <= 8'd0;
                        grant_r <= '0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (!bus.en) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                        valid_r <= 1'b1;
                        done_r  <= ((cnt_r + 8'd1) == BL_C);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 8'd0;
                    grant_r <= '0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel        = sel_r;
    assign bus.valid      = valid_r;
    assign bus.grant      = grant_r;
    assign bus.burst_done = done_r;
    assign bus.busy       = busy_r;

endmodule
